// File: rtl/sram1rw_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : sram1rw_req_ctrl_pkg
// Brief  : Shared defaults, FSM state type and byte-merge helper for the
//          single-port SRAM request controller.
// Rev    : 1.0 - initial release
// ============================================================================
package sram1rw_req_ctrl_pkg;

   localparam int DEFAULT_ADDR_W    = 8;
   localparam int DEFAULT_DATA_W    = 32;
   localparam int DEFAULT_RSP_DEPTH = 2;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_t;

   // Selects the new byte when its enable is set, otherwise keeps the old one.
   function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                             input logic [7:0] new_byte,
                                             input logic       en);
      return en ? new_byte : old_byte;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram1rw_req_ctrl_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module : sram_rsp_fifo
// Brief  : Small response FIFO holding read data until the consumer takes it.
//          Head entry is presented combinationally on rdata.
// Rev    : 1.0 - initial release
// ============================================================================
module sram_rsp_fifo #(
   parameter int DATA_W    = 32,
   parameter int RSP_DEPTH = 2,
   localparam int CNT_W    = $clog2(RSP_DEPTH + 1),
   localparam int PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic [CNT_W-1:0]  count,
   output logic              valid
);

   logic [DATA_W-1:0] mem [RSP_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              full;
   logic              do_pop;
   logic              do_push;

   assign valid   = (count != '0);
   assign full    = (count == CNT_W'(RSP_DEPTH));
   assign do_pop  = pop && valid;
   // A push into a full FIFO is only legal when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap at RSP_DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

   // Storage array; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/sram1rw_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sram1rw_req_ctrl
// Brief  : Valid/ready request front-end for a single-port SRAM macro with
//          active-low strobes. Handles reads, full writes and byte-masked
//          writes (read-modify-write), with an in-order response FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
module sram1rw_req_ctrl
   import sram1rw_req_ctrl_pkg::*;
#(
   parameter int ADDR_W    = DEFAULT_ADDR_W,
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int RSP_DEPTH = DEFAULT_RSP_DEPTH
) (
   input  logic                CE,
   input  logic                RSTB,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [DATA_W/8-1:0] req_be,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [ADDR_W-1:0]   sram_A,
   output logic                sram_CSB,
   output logic                sram_WEB,
   output logic                sram_OEB,
   output logic [DATA_W-1:0]   sram_I,
   input  logic [DATA_W-1:0]   sram_O
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);

   state_t            state;
   logic              rd_inflight;
   logic [ADDR_W-1:0] rmw_addr;
   logic [BE_W-1:0]   rmw_be;
   logic [DATA_W-1:0] rmw_wdata;
   logic [DATA_W-1:0] merged;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    occupancy;
   logic              rd_credit;
   logic              accept;
   logic              acc_read;
   logic              acc_full_wr;
   logic              acc_partial;

   // Reads reserve a FIFO slot at issue, so in-flight reads count as occupied.
   assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(rd_inflight);
   assign rd_credit = occupancy < (CNT_W + 1)'(RSP_DEPTH);

   // Gating with RSTB keeps ready low during reset yet high right after release.
   assign req_ready   = RSTB && (state == IDLE) && (req_we || rd_credit);
   assign accept      = req_valid && req_ready;
   assign acc_read    = accept && !req_we;
   assign acc_full_wr = accept && req_we && (&req_be);
   assign acc_partial = accept && req_we && (|req_be) && !(&req_be);

   // Byte merge of the freshly read word with the registered masked write data.
   always_comb begin
      merged = '0;
      for (int b = 0; b < BE_W; b++)
         merged[b*8 +: 8] = byte_merge(sram_O[b*8 +: 8], rmw_wdata[b*8 +: 8], rmw_be[b]);
   end

   // Macro strobes follow the accepted request so the macro acts on the same edge.
   always_comb begin
      sram_CSB = 1'b1;
      sram_WEB = 1'b1;
      sram_OEB = 1'b1;
      sram_A   = req_addr;
      sram_I   = req_wdata;
      if (state == RMW_WR) begin
         sram_CSB = 1'b0;
         sram_WEB = 1'b0;
         sram_A   = rmw_addr;
         sram_I   = merged;
      end else if (acc_read || acc_partial) begin
         sram_CSB = 1'b0;
         sram_OEB = 1'b0;
      end else if (acc_full_wr) begin
         sram_CSB = 1'b0;
         sram_WEB = 1'b0;
      end
   end

   // Control FSM: IDLE accepts requests, RMW_WR writes back the merged word.
   always_ff @(posedge CE or negedge RSTB) begin
      if (!RSTB) begin
         state       <= IDLE;
         rd_inflight <= 1'b0;
         rmw_addr    <= '0;
         rmw_be      <= '0;
         rmw_wdata   <= '0;
      end else begin
         rd_inflight <= acc_read;
         case (state)
            IDLE: begin
               if (acc_partial) begin
                  state     <= RMW_WR;
                  rmw_addr  <= req_addr;
                  rmw_be    <= req_be;
                  rmw_wdata <= req_wdata;
               end
            end
            RMW_WR:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   sram_rsp_fifo #(
      .DATA_W    (DATA_W),
      .RSP_DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (CE),
      .rst_n (RSTB),
      .push  (rd_inflight),
      .wdata (sram_O),
      .pop   (rsp_valid && rsp_ready),
      .rdata (rsp_rdata),
      .count (fifo_count),
      .valid (rsp_valid)
   );

endmodule
`default_nettype wire

// File: tb/tb_sram1rw_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sram1rw_req_ctrl
// Brief  : Directed bench for sram1rw_req_ctrl with a behavioural 256x32
//          single-port SRAM macro model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sram1rw_req_ctrl;

   logic        CE;
   logic        RSTB;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [3:0]  req_be;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [7:0]  sram_A;
   logic        sram_CSB;
   logic        sram_WEB;
   logic        sram_OEB;
   logic [31:0] sram_I;
   logic [31:0] sram_O;

   logic        f_push;
   logic        f_pop;
   logic [31:0] f_wdata;
   logic [31:0] f_rdata;
   logic [1:0]  f_count;
   logic        f_valid;

   int total = 0;
   int bad   = 0;
   int cs_cnt = 0;

   logic [31:0] mem [256];

   sram1rw_req_ctrl #(.ADDR_W(8), .DATA_W(32), .RSP_DEPTH(2)) dut (
      .CE        (CE),
      .RSTB      (RSTB),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_be    (req_be),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .sram_A    (sram_A),
      .sram_CSB  (sram_CSB),
      .sram_WEB  (sram_WEB),
      .sram_OEB  (sram_OEB),
      .sram_I    (sram_I),
      .sram_O    (sram_O)
   );

   sram_rsp_fifo #(.DATA_W(32), .RSP_DEPTH(2)) u_fifo (
      .clk   (CE),
      .rst_n (RSTB),
      .push  (f_push),
      .wdata (f_wdata),
      .pop   (f_pop),
      .rdata (f_rdata),
      .count (f_count),
      .valid (f_valid)
   );

   initial CE = 1'b0;
   always #5 CE = ~CE;

   // SRAM1RW256x32 behavioural model: O updates only on reads and then holds.
   always @(posedge CE) begin
      if (!sram_CSB) begin
         cs_cnt <= cs_cnt + 1;
         if (!sram_WEB)
            mem[sram_A] <= sram_I;
         else if (!sram_OEB)
            sram_O <= mem[sram_A];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CE);
      #1;
   endtask

   task automatic wr_full(input logic [7:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = a; req_wdata = d;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic rd_check(input logic [7:0] a, input logic [31:0] exp, input string tag);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      #1;
      check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      check({tag, "_early"}, {31'd0, rsp_valid}, 32'd0);
      tick();
      check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_data"}, rsp_rdata, exp);
      tick();
   endtask

   initial begin
      int c0;
      int n_acc;
      int n_rsp;
      logic acc;

      RSTB = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
      req_addr = 8'h00; req_wdata = 32'h0; rsp_ready = 1'b1;
      f_push = 1'b0; f_pop = 1'b0; f_wdata = 32'h0;

      // reset state
      #2;
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_strobes", {29'd0, sram_CSB, sram_WEB, sram_OEB}, 32'h7);
      tick();
      tick();
      RSTB = 1'b1;
      #1;
      check("ready_after_rst", {31'd0, req_ready}, 32'd1);
      tick();

      // full write then read back
      req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 8'h10; req_wdata = 32'hDEADBEEF;
      #1;
      check("wr_strobes", {29'd0, sram_CSB, sram_WEB, sram_OEB}, 32'h1);
      check("wr_data", sram_I, 32'hDEADBEEF);
      tick();
      req_valid = 1'b0;
      req_we = 1'b0; req_valid = 1'b1; req_addr = 8'h10;
      #1;
      check("rd_strobes", {29'd0, sram_CSB, sram_WEB, sram_OEB}, 32'h2);
      check("rd_addr", {24'd0, sram_A}, 32'h10);
      req_valid = 1'b0;
      rd_check(8'h10, 32'hDEADBEEF, "rd10");
      check("rsp_popped", {31'd0, rsp_valid}, 32'd0);

      // partial write via read-modify-write
      wr_full(8'h05, 32'h11223344);
      req_valid = 1'b1; req_we = 1'b1; req_be = 4'b0101; req_addr = 8'h05; req_wdata = 32'hAABBCCDD;
      #1;
      check("rmw_rd_strobes", {29'd0, sram_CSB, sram_WEB, sram_OEB}, 32'h2);
      tick();
      req_valid = 1'b0;
      check("rmw_busy", {31'd0, req_ready}, 32'd0);
      check("rmw_wr_strobes", {29'd0, sram_CSB, sram_WEB, sram_OEB}, 32'h1);
      check("rmw_addr", {24'd0, sram_A}, 32'h05);
      check("rmw_merge", sram_I, 32'h11BB33DD);
      tick();
      check("rmw_done_ready", {31'd0, req_ready}, 32'd1);
      rd_check(8'h05, 32'h11BB33DD, "rd05");

      // back-to-back reads with a stalled consumer
      for (int i = 0; i < 4; i++)
         wr_full(i[7:0], 32'hA0A00000 + i);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00;
      #1;
      check("b2b_ready0", {31'd0, req_ready}, 32'd1);
      tick();
      req_addr = 8'h01;
      #1;
      check("b2b_ready1", {31'd0, req_ready}, 32'd1);
      tick();
      req_addr = 8'h02;
      #1;
      check("b2b_blocked", {31'd0, req_ready}, 32'd0);
      check("b2b_head", rsp_rdata, 32'hA0A00000);
      tick();
      check("b2b_blocked2", {31'd0, req_ready}, 32'd0);
      check("b2b_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("b2b_hold_data", rsp_rdata, 32'hA0A00000);
      rsp_ready = 1'b1;
      n_acc = 2;
      n_rsp = 0;
      for (int cyc = 0; cyc < 40 && n_rsp < 4; cyc++) begin
         req_valid = (n_acc < 4);
         req_addr  = n_acc[7:0];
         #1;
         acc = req_valid && req_ready;
         if (rsp_valid && rsp_ready) begin
            check("b2b_order", rsp_rdata, 32'hA0A00000 + n_rsp);
            n_rsp++;
         end
         tick();
         if (acc) n_acc++;
      end
      req_valid = 1'b0;
      check("b2b_rsp_count", n_rsp, 32'd4);
      tick();

      // byte-enable zero write leaves the macro untouched
      wr_full(8'h20, 32'h55AA55AA);
      c0 = cs_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_be = 4'h0; req_addr = 8'h20; req_wdata = 32'hFFFFFFFF;
      #1;
      check("be0_csb", {31'd0, sram_CSB}, 32'd1);
      check("be0_ready", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      check("be0_no_access", cs_cnt, c0);
      rd_check(8'h20, 32'h55AA55AA, "rd20");

      // reset aborts a pending RMW write
      wr_full(8'h30, 32'h0BADF00D);
      req_valid = 1'b1; req_we = 1'b1; req_be = 4'b0011; req_addr = 8'h30; req_wdata = 32'h12345678;
      tick();
      req_valid = 1'b0;
      check("rst_rmw_busy", {31'd0, req_ready}, 32'd0);
      RSTB = 1'b0;
      #1;
      check("rst_rmw_strobes", {29'd0, sram_CSB, sram_WEB, sram_OEB}, 32'h7);
      check("rst_rmw_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
      RSTB = 1'b1;
      #1;
      check("rst_rmw_idle", {31'd0, req_ready}, 32'd1);
      rd_check(8'h30, 32'h0BADF00D, "rd30");

      // reset with a read in flight drops its response
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
      tick();
      req_valid = 1'b0;
      RSTB = 1'b0;
      #1;
      RSTB = 1'b1;
      tick();
      check("inflight_drop1", {31'd0, rsp_valid}, 32'd0);
      tick();
      check("inflight_drop2", {31'd0, rsp_valid}, 32'd0);

      // FIFO push and pop on the same edge while full
      f_push = 1'b1; f_wdata = 32'h1;
      tick();
      f_wdata = 32'h2;
      tick();
      f_push = 1'b0;
      check("fifo_full", {30'd0, f_count}, 32'd2);
      check("fifo_head1", f_rdata, 32'h1);
      f_push = 1'b1; f_wdata = 32'h3; f_pop = 1'b1;
      tick();
      f_push = 1'b0;
      check("fifo_pp_count", {30'd0, f_count}, 32'd2);
      check("fifo_pp_head", f_rdata, 32'h2);
      tick();
      check("fifo_head3", f_rdata, 32'h3);
      check("fifo_count1", {30'd0, f_count}, 32'd1);
      tick();
      f_pop = 1'b0;
      check("fifo_empty", {31'd0, f_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
